fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the in-order RISC-V pipeline. Holds the PC, issues word-aligned requests to the instruction cache with a single request outstanding, and buffers returned instructions with their PCs in a 2-entry FIFO. It presents them to the decoder through a valid/ready handshake. Branch and jump redirects from execute flush the buffer and discard any in-flight response.

## Interface

Parameters:
- `INSTR_SIZE`, default `` `WORD_SIZE `` (32): instruction and PC width.
- `RESET_PC`, default `'h0000_1000`: PC of the first fetch after reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `icache_req_valid`  out  1  request valid.
- `icache_req_addr`  out  INSTR_SIZE  request address, always 4-byte aligned.
- `icache_req_ready`  in  1  cache accepts the request this cycle.
- `icache_resp_valid`  in  1  response valid; never in the same cycle as its request acceptance.
- `icache_resp_instr`  in  INSTR_SIZE  returned instruction word.
- `redirect_valid`  in  1  redirect from execute (taken branch or jump).
- `redirect_pc`  in  INSTR_SIZE  redirect target; bits [1:0] are forced to 0.
- `instr_valid`  out  1  head of buffer valid toward the decoder.
- `instr`  out  INSTR_SIZE  instruction to the decoder's `instr` input.
- `instr_pc`  out  INSTR_SIZE  PC of `instr`.
- `decode_ready`  in  1  decoder consumes the head this cycle.

## Operation

- FSM states:
  - REQ: no request outstanding.
  - WAIT: request outstanding, response kept.
  - DROP: request outstanding, response discarded.
- Space rule: REQ asserts `icache_req_valid` only when `count < 2`. No slot needs reserving, because only one request is ever outstanding and it is issued only with a free slot.
- In REQ, `icache_req_addr = pc`.
- REQ transitions:
  - Handshake (`valid && ready`) → WAIT; `pc <= pc + 4`, wrapping modulo 2^32.
  - No handshake → stay in REQ.
- In WAIT, `icache_resp_valid` pushes `{pc_of_request, instr}` into the FIFO → REQ.
- In DROP, `icache_resp_valid` → REQ; the data is not pushed.
- Pop: `instr_valid && decode_ready`. Push and pop in the same cycle leaves `count` unchanged.
- Redirect has the highest priority:
  - Flushes the FIFO (`count <= 0`); a pop in the same cycle is ignored.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - From WAIT → DROP. A response arriving in the redirect cycle is discarded and the state goes → REQ.
  - From REQ: a request accepted in the same cycle → DROP; otherwise → REQ.
  - From DROP: stays DROP, unless the response arrives that cycle → REQ.
- `instr_valid = (count != 0)`. `instr`/`instr_pc` come from the FIFO head and are stable while valid and not popped.
- Reset values:
  - `pc = RESET_PC`, state REQ, `count = 0`, FIFO pointers 0.
  - All outputs 0 while `rst_n = 0`; `icache_req_addr` reads `RESET_PC` once reset is released.

## Timing

- First request: the first rising edge after `rst_n` deasserts sees `icache_req_valid = 1` with address `RESET_PC`.
- Fetch-to-decode latency: a response in cycle N gives `instr_valid = 1` in cycle N+1 (registered FIFO).
- Throughput: with a 1-cycle cache and `decode_ready = 1`, one instruction every 2 cycles.
- Redirect: the request to the new PC is visible in the cycle after redirect if the state is REQ. From DROP it is visible in the cycle after the stale response.
- Buffer full (`count = 2`): no request; the PC is held.
- Reset mid-operation: immediate return to reset state. The outstanding cache transaction is the cache's responsibility to abort.

## Structure

- Shared defines header: `` `WORD_SIZE ``, `` `PC_INCREMENT `` (4), the fetch FSM state enum typedef, and the default reset PC.
- Sub-module `fetch_buffer`: parameterised 2-entry FIFO (width `2*INSTR_SIZE`) with push, pop, flush, count, head, async active-low reset.
- The FSM and PC register live in `fetch_stage`.

## Test plan

- Reset release, cache always ready, 1-cycle response returning `'h003100b3` then `'h00108093`, decoder ready → decoder sees `instr_pc = 'h1000` then `'h1004`, matching instruction words.
- `decode_ready = 0` for 10 cycles → exactly 2 instructions buffered (PCs `'h1000`, `'h1004`), no further request, PC held at `'h1008`. Releasing ready drains them in order and fetch resumes at `'h1008`.
- Redirect to `'h2002` while in WAIT with 1 buffered entry → buffer empty next cycle, stale response dropped, next request address `'h2000`.
- Redirect in the same cycle as a response and a pop → response discarded, `count = 0`, next request at the redirect target.
- Cache `icache_req_ready` low for 3 cycles → `icache_req_valid` and `icache_req_addr` held stable, PC advances only on acceptance.
- PC `'hFFFF_FFFC` fetched → next request address `'h0000_0000`.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: word size, PC step, FSM state encoding, reset PC.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef PC_INCREMENT
`define PC_INCREMENT 4
`endif

package fetch_stage_pkg;

    // PC of the first fetch after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

    // REQ: nothing outstanding, WAIT: outstanding and kept, DROP: outstanding and discarded
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding {pc, instr} pairs between the icache and the decoder.
module fetch_buffer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [1:0][WIDTH-1:0] mem;
    logic                  wr_ptr;
    logic                  rd_ptr;

    assign dout = mem[rd_ptr];

    // Storage, pointers and occupancy; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding icache FSM, 2-entry output buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned           INSTR_SIZE = `WORD_SIZE,
    parameter logic [INSTR_SIZE-1:0] RESET_PC   = INSTR_SIZE'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  icache_req_valid,
    output logic [INSTR_SIZE-1:0] icache_req_addr,
    input  logic                  icache_req_ready,
    input  logic                  icache_resp_valid,
    input  logic [INSTR_SIZE-1:0] icache_resp_instr,
    input  logic                  redirect_valid,
    input  logic [INSTR_SIZE-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instr,
    output logic [INSTR_SIZE-1:0] instr_pc,
    input  logic                  decode_ready
);

    localparam logic [INSTR_SIZE-1:0] PC_INC = INSTR_SIZE'(`PC_INCREMENT);

    fetch_state_t            state;
    logic [INSTR_SIZE-1:0]   pc;
    logic [INSTR_SIZE-1:0]   req_pc;
    logic [INSTR_SIZE-1:0]   redirect_tgt;
    logic [1:0]              count;
    logic [2*INSTR_SIZE-1:0] head;
    logic                    req_fire;
    logic                    resp_push;
    logic                    pop;
    logic                    redirect_lsb_unused;

    // Low address bits of the redirect target are dropped to keep fetches word aligned
    assign redirect_tgt        = {redirect_pc[INSTR_SIZE-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // A request is only issued with a free slot, so the response always has room
    assign icache_req_valid = rst_n && (state == FS_REQ) && (count != 2'd2);
    assign icache_req_addr  = rst_n ? pc : '0;
    assign req_fire         = icache_req_valid && icache_req_ready;

    // A redirect kills the response arriving with it and any pop in that cycle
    assign resp_push = (state == FS_WAIT) && icache_resp_valid && !redirect_valid;
    assign pop       = instr_valid && decode_ready && !redirect_valid;

    assign instr_valid        = (count != 2'd0);
    assign {instr_pc, instr}  = head;

    // Fetch FSM and PC; redirect overrides the sequential PC step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FS_REQ;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (req_fire) begin
                req_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= redirect_tgt;
            end else if (req_fire) begin
                pc <= pc + PC_INC;
            end
            unique case (state)
                FS_REQ: begin
                    if (req_fire) begin
                        state <= redirect_valid ? FS_DROP : FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (icache_resp_valid) begin
                        state <= FS_REQ;
                    end else if (redirect_valid) begin
                        state <= FS_DROP;
                    end
                end
                FS_DROP: begin
                    if (icache_resp_valid) begin
                        state <= FS_REQ;
                    end
                end
                default: state <= FS_REQ;
            endcase
        end
    end

    fetch_buffer #(
        .WIDTH (2*INSTR_SIZE)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (resp_push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({req_pc, icache_resp_instr}),
        .dout  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: 1-cycle icache model, scoreboard of delivered instructions.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready = 1'b1;
    logic        icache_resp_valid = 1'b0;
    logic [31:0] icache_resp_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready = 1'b1;

    always #5 clk = ~clk;

    fetch_stage #(
        .INSTR_SIZE (32),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_instr (icache_resp_instr),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .instr_valid       (instr_valid),
        .instr             (instr),
        .instr_pc          (instr_pc),
        .decode_ready      (decode_ready)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct packed {
        logic [31:0] rpc;
        logic [31:0] want;
    } vec_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    int          n_acc = 0;
    logic        pend = 1'b0;
    logic        drop = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] first_acc_addr = '0;
    logic        hold_resp = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h003100b3;
        if (a == 32'h0000_1004) return 32'h00108093;
        return {a[15:0], 16'h0013} ^ 32'h5a5a_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // One clock cycle: sample at negedge+1, update the model, advance, drive next inputs
    task automatic tick();
        logic        acc;
        logic        pp;
        logic        resp;
        logic        red;
        logic [31:0] rtgt;
        exp_t        e;
        #1;
        acc  = icache_req_valid && icache_req_ready;
        pp   = instr_valid && decode_ready;
        resp = icache_resp_valid;
        red  = redirect_valid;
        rtgt = {redirect_pc[31:2], 2'b00};
        if (icache_req_valid) check("req_addr", icache_req_addr, exp_pc);
        if (acc) check("one_outstanding", 32'(pend), 32'd0);
        if (pp && !red) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_instr: pc %h delivered, scoreboard empty", instr_pc);
            end else begin
                e = sb.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.word);
            end
            n_pop++;
        end
        if (resp) begin
            if (!drop && !red) sb.push_back('{pc: pend_addr, word: icache_resp_instr});
            pend = 1'b0;
            drop = 1'b0;
        end
        if (red) begin
            sb.delete();
            if (pend) drop = 1'b1;
        end
        if (acc) begin
            if (n_acc == 0) first_acc_addr = exp_pc;
            n_acc++;
            pend      = 1'b1;
            pend_addr = exp_pc;
            drop      = red;
        end
        if (red) exp_pc = rtgt;
        else if (acc) exp_pc = exp_pc + 32'd4;
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        if (!hold_resp) begin
            icache_resp_valid = pend;
            icache_resp_instr = pend ? mem_word(pend_addr) : 32'h0;
        end else begin
            icache_resp_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input bit chk);
        rst_n             = 1'b0;
        icache_resp_valid = 1'b0;
        redirect_valid    = 1'b0;
        icache_req_ready  = 1'b1;
        decode_ready      = 1'b1;
        hold_resp         = 1'b0;
        #1;
        if (chk) begin
            check("rst_req_valid", 32'(icache_req_valid), 32'd0);
            check("rst_req_addr", icache_req_addr, 32'h0);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", instr, 32'h0);
            check("rst_instr_pc", instr_pc, 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        pend   = 1'b0;
        drop   = 1'b0;
        exp_pc = RST_PC;
        n_acc  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   found;
        logic [31:0] a;
        vecs[0] = '{rpc: 32'h0000_2002, want: 32'h0000_2000};
        vecs[1] = '{rpc: 32'h0000_2003, want: 32'h0000_2000};
        vecs[2] = '{rpc: 32'hFFFF_FFFF, want: 32'hFFFF_FFFC};
        vecs[3] = '{rpc: 32'h0000_0000, want: 32'h0000_0000};
        vecs[4] = '{rpc: 32'h8001_234D, want: 32'h8001_234C};
        vecs[5] = '{rpc: 32'h0000_1235, want: 32'h0000_1234};

        // Reset values and first request
        do_reset(1);
        #1;
        check("first_req_valid", 32'(icache_req_valid), 32'd1);
        check("first_req_addr", icache_req_addr, RST_PC);

        // Streaming with a 1-cycle cache: one instruction every two cycles
        repeat (4) tick();
        n_pop = 0;
        repeat (10) tick();
        check("throughput", 32'(n_pop), 32'd5);

        // Decoder stalled: buffer fills to two, fetch stops, PC held
        do_reset(0);
        decode_ready = 1'b0;
        repeat (10) tick();
        check("stall_requests", 32'(n_acc), 32'd2);
        check("full_req_valid", 32'(icache_req_valid), 32'd0);
        check("full_head_valid", 32'(instr_valid), 32'd1);
        check("full_head_pc", instr_pc, 32'h0000_1000);
        check("full_head_instr", instr, 32'h003100b3);
        n_acc = 0;
        decode_ready = 1'b1;
        repeat (6) tick();
        check("resume_addr", first_acc_addr, 32'h0000_1008);

        // Redirect in WAIT with one buffered entry; stale response dropped
        do_reset(0);
        decode_ready = 1'b0;
        tick();
        tick();
        hold_resp = 1'b1;
        tick();
        check("wait_head_valid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        check("flush_valid", 32'(instr_valid), 32'd0);
        check("drop_no_req", 32'(icache_req_valid), 32'd0);
        icache_resp_valid = 1'b1;
        icache_resp_instr = 32'hdead_beef;
        hold_resp         = 1'b0;
        decode_ready      = 1'b1;
        tick();
        check("redir_req_valid", 32'(icache_req_valid), 32'd1);
        check("redir_req_addr", icache_req_addr, 32'h0000_2000);
        repeat (6) tick();

        // Redirect coinciding with a response and a pop
        do_reset(0);
        decode_ready = 1'b0;
        repeat (3) tick();
        check("pre_resp_valid", 32'(instr_valid), 32'd1);
        decode_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        check("race_instr_valid", 32'(instr_valid), 32'd0);
        check("race_req_valid", 32'(icache_req_valid), 32'd1);
        check("race_req_addr", icache_req_addr, 32'h0000_3000);
        repeat (6) tick();

        // Cache backpressure: request held stable until accepted
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (icache_req_valid) found = 1'b1;
            else tick();
        end
        check("stall_setup", 32'(found), 32'd1);
        a = icache_req_addr;
        icache_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(icache_req_valid), 32'd1);
            check("stall_addr", icache_req_addr, a);
            tick();
        end
        icache_req_ready = 1'b1;
        check("stall_release_addr", icache_req_addr, a);
        tick();
        tick();
        check("after_stall_addr", icache_req_addr, a + 32'd4);

        // PC wrap at the top of the address space
        icache_req_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        check("wrap_start_addr", icache_req_addr, 32'hFFFF_FFFC);
        icache_req_ready = 1'b1;
        tick();
        tick();
        check("wrap_valid", 32'(icache_req_valid), 32'd1);
        check("wrap_addr", icache_req_addr, 32'h0000_0000);
        repeat (4) tick();

        // Redirect alignment table, applied with the cache not accepting
        icache_req_ready = 1'b0;
        repeat (3) tick();
        foreach (vecs[i]) begin
            redirect_valid = 1'b1;
            redirect_pc    = vecs[i].rpc;
            tick();
            check("align_valid", 32'(icache_req_valid), 32'd1);
            check("align_addr", icache_req_addr, vecs[i].want);
        end

        // Final run and drain; every expected instruction must have been delivered
        icache_req_ready = 1'b1;
        repeat (8) tick();
        icache_req_ready = 1'b0;
        repeat (4) tick();
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
        check("drain_instr_valid", 32'(instr_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
